// File: rtl/yadan_defs.sv
// Shared core definitions: aluop codes, reset level, memory-op
// classification helpers and LSU state encoding.
package yadan_defs;

    localparam logic RST_ENABLE = 1'b1;

    localparam int ALUOP_BUS_W = 8;

    localparam logic [ALUOP_BUS_W-1:0] EXE_NONE = 8'h00;
    localparam logic [ALUOP_BUS_W-1:0] EXE_ADD  = 8'h01;
    localparam logic [ALUOP_BUS_W-1:0] EXE_SUB  = 8'h02;
    localparam logic [ALUOP_BUS_W-1:0] EXE_LB   = 8'h20;
    localparam logic [ALUOP_BUS_W-1:0] EXE_LH   = 8'h21;
    localparam logic [ALUOP_BUS_W-1:0] EXE_LW   = 8'h22;
    localparam logic [ALUOP_BUS_W-1:0] EXE_LBU  = 8'h23;
    localparam logic [ALUOP_BUS_W-1:0] EXE_LHU  = 8'h24;
    localparam logic [ALUOP_BUS_W-1:0] EXE_SB   = 8'h28;
    localparam logic [ALUOP_BUS_W-1:0] EXE_SH   = 8'h29;
    localparam logic [ALUOP_BUS_W-1:0] EXE_SW   = 8'h2A;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } lsu_state_e;

    function automatic logic is_load(input logic [ALUOP_BUS_W-1:0] op);
        return (op == EXE_LB) || (op == EXE_LH) || (op == EXE_LW) ||
               (op == EXE_LBU) || (op == EXE_LHU);
    endfunction

    function automatic logic is_store(input logic [ALUOP_BUS_W-1:0] op);
        return (op == EXE_SB) || (op == EXE_SH) || (op == EXE_SW);
    endfunction

    function automatic logic is_byte_op(input logic [ALUOP_BUS_W-1:0] op);
        return (op == EXE_LB) || (op == EXE_LBU) || (op == EXE_SB);
    endfunction

    function automatic logic is_half_op(input logic [ALUOP_BUS_W-1:0] op);
        return (op == EXE_LH) || (op == EXE_LHU) || (op == EXE_SH);
    endfunction

    function automatic logic is_word_op(input logic [ALUOP_BUS_W-1:0] op);
        return (op == EXE_LW) || (op == EXE_SW);
    endfunction

    function automatic logic is_unsigned_ld(input logic [ALUOP_BUS_W-1:0] op);
        return (op == EXE_LBU) || (op == EXE_LHU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and alignment/extension for loads.
// Purely combinational; shared by request and writeback paths.
module lsu_align
    import yadan_defs::*;
#(
    parameter int ALUOP_W = 8,
    parameter int DATA_W  = 32
) (
    input  logic [ALUOP_W-1:0] op,
    input  logic [1:0]         addr_lo,
    input  logic [DATA_W-1:0]  op2,
    input  logic [DATA_W-1:0]  rdata,
    output logic [3:0]         be,
    output logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  ldata,
    output logic               misalign
);

    logic [DATA_W-1:0] shifted;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic              uns;

    // Lane select, byte enables and sign/zero extension by access size
    always_comb begin
        be       = 4'b0000;
        wdata    = op2;
        ldata    = '0;
        misalign = 1'b0;
        shifted  = rdata >> {addr_lo, 3'b000};
        byte_v   = shifted[7:0];
        half_v   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        uns      = is_unsigned_ld(op);
        unique case (1'b1)
            is_byte_op(op): begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{op2[7:0]}};
                ldata = uns ? {24'b0, byte_v}
                            : {{24{byte_v[7]}}, byte_v};
            end
            is_half_op(op): begin
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{op2[15:0]}};
                ldata    = uns ? {16'b0, half_v}
                               : {{16{half_v[15]}}, half_v};
                misalign = addr_lo[0];
            end
            is_word_op(op): begin
                be       = 4'b1111;
                wdata    = op2;
                ldata    = rdata;
                misalign = (addr_lo != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: issues req/ack bus accesses,
// stalls upstream while busy and forwards writeback to mem_wb.
module mem_lsu
    import yadan_defs::*;
#(
    parameter int ALUOP_W = 8,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_wreg_i,
    input  logic [4:0]         mem_wreg_addr_i,
    input  logic [DATA_W-1:0]  mem_wreg_data_i,
    input  logic [ALUOP_W-1:0] mem_aluop_i,
    input  logic [ADDR_W-1:0]  mem_memaddr_i,
    input  logic [DATA_W-1:0]  mem_operand2_i,
    output logic               dbus_req_o,
    output logic               dbus_we_o,
    output logic [ADDR_W-1:0]  dbus_addr_o,
    output logic [3:0]         dbus_be_o,
    output logic [DATA_W-1:0]  dbus_wdata_o,
    input  logic               dbus_ack_i,
    input  logic [DATA_W-1:0]  dbus_rdata_i,
    output logic               stall_req_o,
    output logic               misalign_o,
    output logic               wb_wreg_o,
    output logic [4:0]         wb_wreg_addr_o,
    output logic [DATA_W-1:0]  wb_wreg_data_o
);

    lsu_state_e        state_q;
    lsu_state_e        state_d;
    logic [DATA_W-1:0] load_buf;
    logic [3:0]        be_c;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] ldata_c;
    logic              mis_c;
    logic              ld_c;
    logic              st_c;
    logic              start;

    assign ld_c = is_load(mem_aluop_i);
    assign st_c = is_store(mem_aluop_i);

    lsu_align #(
        .ALUOP_W (ALUOP_W),
        .DATA_W  (DATA_W)
    ) u_align (
        .op       (mem_aluop_i),
        .addr_lo  (mem_memaddr_i[1:0]),
        .op2      (mem_operand2_i),
        .rdata    (load_buf),
        .be       (be_c),
        .wdata    (wdata_c),
        .ldata    (ldata_c),
        .misalign (mis_c)
    );

    // Next state, stall, misalign and writeback selection
    always_comb begin
        state_d        = state_q;
        start          = 1'b0;
        stall_req_o    = 1'b0;
        misalign_o     = 1'b0;
        wb_wreg_o      = 1'b0;
        wb_wreg_addr_o = mem_wreg_addr_i;
        wb_wreg_data_o = mem_wreg_data_i;
        unique case (state_q)
            S_IDLE: begin
                if ((ld_c || st_c) && mis_c) begin
                    misalign_o = 1'b1;
                end else if (ld_c || st_c) begin
                    stall_req_o = 1'b1;
                    start       = 1'b1;
                    state_d     = S_BUS;
                end else begin
                    wb_wreg_o = mem_wreg_i;
                end
            end
            S_BUS: begin
                stall_req_o = 1'b1;
                if (dbus_ack_i) state_d = S_DONE;
            end
            S_DONE: begin
                wb_wreg_o      = ld_c & mem_wreg_i;
                wb_wreg_data_o = ldata_c;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register, registered bus request and load buffer
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q      <= S_IDLE;
            dbus_req_o   <= 1'b0;
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= '0;
            dbus_be_o    <= 4'b0000;
            dbus_wdata_o <= '0;
            load_buf     <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                dbus_req_o   <= 1'b1;
                dbus_we_o    <= st_c;
                dbus_addr_o  <= {mem_memaddr_i[ADDR_W-1:2], 2'b00};
                dbus_be_o    <= be_c;
                dbus_wdata_o <= wdata_c;
            end else if (state_q == S_BUS && dbus_ack_i) begin
                dbus_req_o   <= 1'b0;
                dbus_we_o    <= 1'b0;
                dbus_addr_o  <= '0;
                dbus_be_o    <= 4'b0000;
                dbus_wdata_o <= '0;
                load_buf     <= dbus_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu.
// Inputs change 1ns after posedge; outputs sampled on negedge.
module tb_mem_lsu;
    import yadan_defs::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_wreg_i;
    logic [4:0]  mem_wreg_addr_i;
    logic [31:0] mem_wreg_data_i;
    logic [7:0]  mem_aluop_i;
    logic [31:0] mem_memaddr_i;
    logic [31:0] mem_operand2_i;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_ack_i;
    logic [31:0] dbus_rdata_i;
    logic        stall_req_o;
    logic        misalign_o;
    logic        wb_wreg_o;
    logic [4:0]  wb_wreg_addr_o;
    logic [31:0] wb_wreg_data_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] obs_addr;
    logic [3:0]  obs_be;
    logic        obs_we;
    logic [31:0] obs_wdata;
    logic        obs_stable;
    int          obs_stall;
    logic        obs_wb;
    logic [4:0]  obs_wb_addr;
    logic [31:0] obs_wb_data;
    logic        obs_done_req;

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk             (clk),
        .rst             (rst),
        .mem_wreg_i      (mem_wreg_i),
        .mem_wreg_addr_i (mem_wreg_addr_i),
        .mem_wreg_data_i (mem_wreg_data_i),
        .mem_aluop_i     (mem_aluop_i),
        .mem_memaddr_i   (mem_memaddr_i),
        .mem_operand2_i  (mem_operand2_i),
        .dbus_req_o      (dbus_req_o),
        .dbus_we_o       (dbus_we_o),
        .dbus_addr_o     (dbus_addr_o),
        .dbus_be_o       (dbus_be_o),
        .dbus_wdata_o    (dbus_wdata_o),
        .dbus_ack_i      (dbus_ack_i),
        .dbus_rdata_i    (dbus_rdata_i),
        .stall_req_o     (stall_req_o),
        .misalign_o      (misalign_o),
        .wb_wreg_o       (wb_wreg_o),
        .wb_wreg_addr_o  (wb_wreg_addr_o),
        .wb_wreg_data_o  (wb_wreg_data_o)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        mem_aluop_i     = EXE_NONE;
        mem_wreg_i      = 1'b0;
        mem_wreg_addr_i = 5'd0;
        mem_wreg_data_i = 32'h0;
        mem_memaddr_i   = 32'h0;
        mem_operand2_i  = 32'h0;
    endtask

    // Drives one memory op through IDLE/BUS/DONE and records
    // what the bus and writeback looked like; ack after waits.
    task automatic run_access(input logic [7:0] op,
                              input logic [31:0] addr,
                              input logic [31:0] op2,
                              input logic wreg,
                              input logic [31:0] rdata,
                              input int waits);
        mem_aluop_i     = op;
        mem_memaddr_i   = addr;
        mem_operand2_i  = op2;
        mem_wreg_i      = wreg;
        mem_wreg_addr_i = 5'd7;
        mem_wreg_data_i = 32'h5555_AAAA;
        obs_stall       = 0;
        obs_stable      = 1'b1;
        @(negedge clk);
        if (stall_req_o) obs_stall++;
        if (dbus_req_o) obs_stable = 1'b0;
        for (int c = 0; c <= waits; c++) begin
            next_cycle();
            @(negedge clk);
            if (c == 0) begin
                obs_addr  = dbus_addr_o;
                obs_be    = dbus_be_o;
                obs_we    = dbus_we_o;
                obs_wdata = dbus_wdata_o;
            end else if (dbus_addr_o !== obs_addr ||
                         dbus_be_o !== obs_be ||
                         dbus_we_o !== obs_we ||
                         dbus_wdata_o !== obs_wdata) begin
                obs_stable = 1'b0;
            end
            if (dbus_req_o !== 1'b1) obs_stable = 1'b0;
            if (stall_req_o) obs_stall++;
            if (c == waits) begin
                dbus_ack_i   = 1'b1;
                dbus_rdata_i = rdata;
            end
        end
        next_cycle();
        dbus_ack_i   = 1'b0;
        dbus_rdata_i = 32'h0;
        @(negedge clk);
        if (stall_req_o) obs_stall++;
        obs_done_req = dbus_req_o;
        obs_wb       = wb_wreg_o;
        obs_wb_addr  = wb_wreg_addr_o;
        obs_wb_data  = wb_wreg_data_o;
        next_cycle();
        set_nop();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_nop();
        dbus_ack_i   = 1'b0;
        dbus_rdata_i = 32'h0;
        repeat (3) next_cycle();
        @(negedge clk);
        checks++;
        if ({dbus_req_o, dbus_we_o, dbus_be_o} !== 6'b0 ||
            dbus_addr_o !== 32'h0 || dbus_wdata_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: req=%b we=%b be=%b addr=%h wd=%h want 0",
                     dbus_req_o, dbus_we_o, dbus_be_o, dbus_addr_o, dbus_wdata_o);
        end
        checks++;
        if (stall_req_o !== 1'b0 || misalign_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: stall=%b mis=%b want 0 0",
                     stall_req_o, misalign_o);
        end
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_nonmem();
        int reqs = 0;
        mem_aluop_i     = EXE_ADD;
        mem_wreg_i      = 1'b1;
        mem_wreg_addr_i = 5'd3;
        mem_wreg_data_i = 32'h0000_1234;
        mem_memaddr_i   = 32'h5;
        @(negedge clk);
        checks++;
        if (wb_wreg_o !== 1'b1 || wb_wreg_addr_o !== 5'd3 ||
            wb_wreg_data_o !== 32'h0000_1234) begin
            errors++;
            $display("FAIL nonmem_wb: got %b %0d %h want 1 3 00001234",
                     wb_wreg_o, wb_wreg_addr_o, wb_wreg_data_o);
        end
        checks++;
        if (stall_req_o !== 1'b0 || misalign_o !== 1'b0) begin
            errors++;
            $display("FAIL nonmem_ctl: stall=%b mis=%b want 0 0",
                     stall_req_o, misalign_o);
        end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk);
            if (dbus_req_o !== 1'b0) reqs++;
        end
        checks++;
        if (reqs != 0) begin
            errors++;
            $display("FAIL nonmem_req: req high %0d cycles want 0", reqs);
        end
        next_cycle();
        set_nop();
    endtask

    task automatic test_lb();
        run_access(EXE_LB, 32'h103, 32'h0, 1'b1, 32'h80FF_FFFF, 0);
        checks++;
        if (obs_addr !== 32'h100 || obs_be !== 4'b1000 || obs_we !== 1'b0) begin
            errors++;
            $display("FAIL lb_bus: addr=%h be=%b we=%b want 100 1000 0",
                     obs_addr, obs_be, obs_we);
        end
        checks++;
        if (obs_wb !== 1'b1 || obs_wb_addr !== 5'd7 ||
            obs_wb_data !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL lb_wb: got %b %0d %h want 1 7 ffffff80",
                     obs_wb, obs_wb_addr, obs_wb_data);
        end
        checks++;
        if (obs_stall != 2 || obs_done_req !== 1'b0) begin
            errors++;
            $display("FAIL lb_stall: stall=%0d done_req=%b want 2 0",
                     obs_stall, obs_done_req);
        end
    endtask

    task automatic test_lhu_wait();
        run_access(EXE_LHU, 32'h202, 32'h0, 1'b1, 32'hBEEF_1234, 3);
        checks++;
        if (obs_addr !== 32'h200 || obs_be !== 4'b1100 || obs_stable !== 1'b1) begin
            errors++;
            $display("FAIL lhu_bus: addr=%h be=%b stable=%b want 200 1100 1",
                     obs_addr, obs_be, obs_stable);
        end
        checks++;
        if (obs_stall != 5) begin
            errors++;
            $display("FAIL lhu_stall: got %0d want 5", obs_stall);
        end
        checks++;
        if (obs_wb !== 1'b1 || obs_wb_data !== 32'h0000_BEEF) begin
            errors++;
            $display("FAIL lhu_wb: got %b %h want 1 0000beef",
                     obs_wb, obs_wb_data);
        end
    endtask

    task automatic test_stores();
        run_access(EXE_SB, 32'h301, 32'h0000_00AB, 1'b1, 32'h0, 0);
        checks++;
        if (obs_addr !== 32'h300 || obs_be !== 4'b0010 || obs_we !== 1'b1 ||
            obs_wdata !== 32'hABAB_ABAB) begin
            errors++;
            $display("FAIL sb_bus: addr=%h be=%b we=%b wd=%h want 300 0010 1 abababab",
                     obs_addr, obs_be, obs_we, obs_wdata);
        end
        checks++;
        if (obs_wb !== 1'b0 || obs_stall != 2) begin
            errors++;
            $display("FAIL sb_wb: wb=%b stall=%0d want 0 2", obs_wb, obs_stall);
        end
        run_access(EXE_SH, 32'h302, 32'h1234_CAFE, 1'b0, 32'h0, 1);
        checks++;
        if (obs_be !== 4'b1100 || obs_wdata !== 32'hCAFE_CAFE ||
            obs_we !== 1'b1 || obs_stable !== 1'b1) begin
            errors++;
            $display("FAIL sh_bus: be=%b wd=%h we=%b st=%b want 1100 cafecafe 1 1",
                     obs_be, obs_wdata, obs_we, obs_stable);
        end
        run_access(EXE_SW, 32'h400, 32'hDEAD_BEEF, 1'b0, 32'h0, 0);
        checks++;
        if (obs_addr !== 32'h400 || obs_be !== 4'b1111 ||
            obs_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL sw_bus: addr=%h be=%b wd=%h want 400 1111 deadbeef",
                     obs_addr, obs_be, obs_wdata);
        end
    endtask

    task automatic test_sign_ext();
        run_access(EXE_LH, 32'h000, 32'h0, 1'b1, 32'h1234_8001, 0);
        checks++;
        if (obs_be !== 4'b0011 || obs_wb_data !== 32'hFFFF_8001) begin
            errors++;
            $display("FAIL lh_ext: be=%b data=%h want 0011 ffff8001",
                     obs_be, obs_wb_data);
        end
        run_access(EXE_LB, 32'h002, 32'h0, 1'b1, 32'h007F_0000, 0);
        checks++;
        if (obs_be !== 4'b0100 || obs_wb_data !== 32'h0000_007F) begin
            errors++;
            $display("FAIL lb_pos: be=%b data=%h want 0100 0000007f",
                     obs_be, obs_wb_data);
        end
    endtask

    task automatic test_misalign();
        mem_aluop_i     = EXE_LW;
        mem_memaddr_i   = 32'h402;
        mem_wreg_i      = 1'b1;
        mem_wreg_addr_i = 5'd9;
        @(negedge clk);
        checks++;
        if (misalign_o !== 1'b1 || stall_req_o !== 1'b0 || wb_wreg_o !== 1'b0) begin
            errors++;
            $display("FAIL lw_mis: mis=%b stall=%b wb=%b want 1 0 0",
                     misalign_o, stall_req_o, wb_wreg_o);
        end
        next_cycle();
        mem_aluop_i   = EXE_LH;
        mem_memaddr_i = 32'h201;
        @(negedge clk);
        checks++;
        if (misalign_o !== 1'b1 || dbus_req_o !== 1'b0 || stall_req_o !== 1'b0) begin
            errors++;
            $display("FAIL lh_mis: mis=%b req=%b stall=%b want 1 0 0",
                     misalign_o, dbus_req_o, stall_req_o);
        end
        next_cycle();
        set_nop();
        @(negedge clk);
        checks++;
        if (dbus_req_o !== 1'b0 || misalign_o !== 1'b0) begin
            errors++;
            $display("FAIL mis_after: req=%b mis=%b want 0 0",
                     dbus_req_o, misalign_o);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        run_access(EXE_LW, 32'h010, 32'h0, 1'b1, 32'hA5A5_5A5A, 0);
        checks++;
        if (obs_wb_data !== 32'hA5A5_5A5A || obs_done_req !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: data=%h done_req=%b want a5a55a5a 0",
                     obs_wb_data, obs_done_req);
        end
        run_access(EXE_LBU, 32'h011, 32'h0, 1'b1, 32'h0000_C300, 0);
        checks++;
        if (obs_addr !== 32'h010 || obs_be !== 4'b0010 ||
            obs_wb_data !== 32'h0000_00C3 || obs_stall != 2) begin
            errors++;
            $display("FAIL b2b_second: addr=%h be=%b data=%h stall=%0d want 10 0010 c3 2",
                     obs_addr, obs_be, obs_wb_data, obs_stall);
        end
    endtask

    task automatic test_reset_mid();
        mem_aluop_i     = EXE_LW;
        mem_memaddr_i   = 32'h500;
        mem_wreg_i      = 1'b1;
        mem_wreg_addr_i = 5'd4;
        next_cycle();
        @(negedge clk);
        checks++;
        if (dbus_req_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_req: req=%b want 1", dbus_req_o);
        end
        rst = 1'b1;
        next_cycle();
        set_nop();
        @(negedge clk);
        checks++;
        if (dbus_req_o !== 1'b0 || stall_req_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_drop: req=%b stall=%b want 0 0",
                     dbus_req_o, stall_req_o);
        end
        dbus_ack_i   = 1'b1;
        dbus_rdata_i = 32'hFEED_F00D;
        next_cycle();
        rst             = 1'b0;
        mem_aluop_i     = EXE_ADD;
        mem_wreg_i      = 1'b1;
        mem_wreg_addr_i = 5'd2;
        mem_wreg_data_i = 32'h0000_0055;
        next_cycle();
        dbus_ack_i   = 1'b0;
        dbus_rdata_i = 32'h0;
        @(negedge clk);
        checks++;
        if (dbus_req_o !== 1'b0 || stall_req_o !== 1'b0 ||
            wb_wreg_o !== 1'b1 || wb_wreg_data_o !== 32'h0000_0055) begin
            errors++;
            $display("FAIL rstmid_late_ack: req=%b stall=%b wb=%b data=%h want 0 0 1 00000055",
                     dbus_req_o, stall_req_o, wb_wreg_o, wb_wreg_data_o);
        end
        next_cycle();
        set_nop();
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_lb();
        test_lhu_wait();
        test_stores();
        test_sign_ext();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
